// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, programmable baud divider and sticky overflow.
// Define MMIO_UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wrdata,
  input  logic [3:0]  dmem_wrstb,
  output logic [31:0] dmem_rddata,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef MMIO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic PARITY_FLAG = 1'b1;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic PARITY_FLAG = 1'b0;
`endif

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        overflow_reg;
  logic [15:0] baud_div_reg;
  state_t      state_reg;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx_reg;
  logic [15:0] baud_cnt_reg;
  logic [15:0] reload_reg;
  logic        tx_reg;
`ifdef MMIO_UART_TX_PARITY_EN
  logic        parity_reg;
`endif

  logic [1:0]  reg_sel;
  logic        wr_en, full, empty, bit_done, pop, push_req, push, busy;
  logic [AW:0] fifo_count;
  logic [15:0] count_ext;
  logic [15:0] div_eff;
  logic [7:0]  head_byte;
  logic        unused_ok;

  assign reg_sel    = dmem_addr[3:2];
  assign wr_en      = sel & dmem_wrstb[0];
  assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
  assign count_ext  = 16'(fifo_count);
  assign div_eff    = (baud_div_reg == 16'd0) ? 16'd1 : baud_div_reg;
  assign head_byte  = mem[rd_ptr_reg[AW-1:0]];
  assign bit_done   = (baud_cnt_reg == 16'd0);
  assign busy       = (state_reg != S_IDLE);
  // Popping straight out of STOP lets back-to-back frames run without an idle bit.
  assign pop        = !empty && ((state_reg == S_IDLE) || (state_reg == S_STOP && bit_done));
  assign push_req   = wr_en && (reg_sel == 2'd0);
  assign push       = push_req && (!full || pop);
  assign tx         = tx_reg;
  assign unused_ok  = &{1'b0, dmem_addr[31:4], dmem_addr[1:0], dmem_wrdata[31:16], dmem_wrstb[3:1]};

  always_comb begin
    dmem_rddata = 32'd0;
    if (sel) begin
      case (reg_sel)
        2'd1: dmem_rddata = {20'd0, count_ext[3:0], 3'b000, PARITY_FLAG,
                             overflow_reg, empty, full, busy};
        2'd2: dmem_rddata = {16'd0, baud_div_reg};
        default: dmem_rddata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= dmem_wrdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
      baud_div_reg <= DEFAULT_DIV;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_req && !push)
        overflow_reg <= 1'b1;
      else if (wr_en && reg_sel == 2'd1 && dmem_wrdata[3])
        overflow_reg <= 1'b0;
      if (wr_en && reg_sel == 2'd2) baud_div_reg <= dmem_wrdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      shift_reg    <= 8'd0;
      bit_idx_reg  <= 3'd0;
      baud_cnt_reg <= 16'd0;
      reload_reg   <= 16'd1;
      tx_reg       <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else if (pop) begin
      // Frame load: divider is sampled here only, so mid-frame BAUD_DIV writes wait a frame.
      state_reg    <= S_START;
      shift_reg    <= head_byte;
      bit_idx_reg  <= 3'd0;
      reload_reg   <= div_eff;
      baud_cnt_reg <= div_eff - 16'd1;
      tx_reg       <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_reg   <= ^head_byte;
`endif
    end else if (state_reg != S_IDLE) begin
      if (!bit_done) begin
        baud_cnt_reg <= baud_cnt_reg - 16'd1;
      end else begin
        baud_cnt_reg <= reload_reg - 16'd1;
        case (state_reg)
          S_START: begin
            state_reg <= S_DATA;
            tx_reg    <= shift_reg[0];
          end
          S_DATA: begin
            if (bit_idx_reg == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              state_reg <= S_PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= S_STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end
`ifdef MMIO_UART_TX_PARITY_EN
          S_PARITY: begin
            state_reg <= S_STOP;
            tx_reg    <= 1'b1;
          end
`endif
          S_STOP: begin
            state_reg <= S_IDLE;
            tx_reg    <= 1'b1;
          end
          default: begin
            state_reg <= S_IDLE;
            tx_reg    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: expected frames are queued at DATA writes and checked bit by bit on tx.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

`ifdef MMIO_UART_TX_PARITY_EN
  localparam int          NBITS   = 11;
  localparam logic [31:0] PAR_BIT = 32'h10;
`else
  localparam int          NBITS   = 10;
  localparam logic [31:0] PAR_BIT = 32'h0;
`endif
  localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_BAUD = 32'h8, A_RSVD = 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstb = 4'd0;
  logic [31:0] rdata;
  logic        tx;

  mmio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .dmem_addr(addr), .dmem_wrdata(wdata),
    .dmem_wrstb(wstb), .dmem_rddata(rdata), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; int div; } frame_t;
  frame_t exp_q[$];
  int     frame_starts[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int edge_cyc);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; wstb = 4'b0001;
    @(posedge clk);
    #1;
    edge_cyc = cyc;
    sel = 1'b0; wstb = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    sel = 1'b1; addr = a; wstb = 4'b0000;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [31:0] st;
    int n = 0;
    do begin
      @(posedge clk); #2;
      bus_read(A_STAT, st);
      n++;
    end while ((st[0] || !st[2]) && n < budget);
    check(tag, st & 32'h5, 32'h4);
  endtask

  // Monitor: a falling tx outside a frame starts the next expected frame.
  frame_t      cur;
  logic [10:0] bits;
  initial begin : monitor
    int bad;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", {31'd0, tx}, 32'd1);
          while (rst_n && tx === 1'b0) @(negedge clk);
        end else begin
          cur = exp_q.pop_front();
          frame_starts.push_back(cyc);
          $display("frame data=0x%02h div=%0d start_cyc=%0d", cur.data, cur.div, cyc);
          bits = '1;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = cur.data[i];
          if (NBITS == 11) bits[9] = ^cur.data;
          aborted = 1'b0;
          for (int b = 0; b < NBITS && !aborted; b++) begin
            bad = 0;
            for (int k = 0; k < cur.div && !aborted; k++) begin
              if (b != 0 || k != 0) @(negedge clk);
              if (!rst_n) aborted = 1'b1;
              else if (tx !== bits[b]) bad++;
            end
            if (!aborted) check($sformatf("frame_%02h_bit%0d_bad_cycles", cur.data, b), bad, 32'd0);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] st;
    int wc, nbusy, n;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("reset_tx", {31'd0, tx}, 32'd1);
    bus_read(A_STAT, st);  check("reset_status", st, 32'h4 | PAR_BIT);
    bus_read(A_BAUD, st);  check("reset_baud", st, 32'd434);
    addr = A_BAUD; #1;     check("unselected_read", rdata, 32'd0);

    // Single byte, div 4
    bus_write(A_BAUD, 32'd4, wc);
    exp_q.push_back('{8'hA5, 4});
    bus_write(A_DATA, 32'hA5, wc);
    nbusy = 0;
    for (int k = 0; k < NBITS * 4; k++) begin
      @(posedge clk); #2;
      bus_read(A_STAT, st);
      if (st[0]) nbusy++;
    end
    check("single_busy_cycles", nbusy, NBITS * 4);
    @(posedge clk); #2;
    bus_read(A_STAT, st);  check("single_idle_after", st, 32'h4 | PAR_BIT);
    check("single_start_count", frame_starts.size(), 32'd1);
    if (frame_starts.size() >= 1) check("single_start_latency", frame_starts[0] - wc, 32'd1);

    // Back-to-back, div 2
    frame_starts.delete();
    bus_write(A_BAUD, 32'd2, wc);
    exp_q.push_back('{8'h00, 2});
    exp_q.push_back('{8'hFF, 2});
    bus_write(A_DATA, 32'h00, wc);
    bus_write(A_DATA, 32'hFF, wc);
    n = 0;
    while (frame_starts.size() < 2 && n < 200) begin @(posedge clk); #2; n++; end
    bus_read(A_STAT, st);  check("b2b_empty_after_pop", st & 32'hF07, 32'h005);
    check("b2b_start_count", frame_starts.size(), 32'd2);
    if (frame_starts.size() >= 2) check("b2b_gap", frame_starts[1] - frame_starts[0], NBITS * 2);
    wait_idle("b2b_drain", 200);

    // Divider change mid-frame: 3 -> 6
    frame_starts.delete();
    bus_write(A_BAUD, 32'd3, wc);
    exp_q.push_back('{8'h3C, 3});
    exp_q.push_back('{8'hC3, 6});
    bus_write(A_DATA, 32'h3C, wc);
    bus_write(A_DATA, 32'hC3, wc);
    repeat (5) @(posedge clk);
    bus_write(A_BAUD, 32'd6, wc);
    wait_idle("divchg_drain", 300);
    check("divchg_start_count", frame_starts.size(), 32'd2);
    if (frame_starts.size() >= 2) check("divchg_frame1_len", frame_starts[1] - frame_starts[0], NBITS * 3);

    // Parity-sensitive byte
    bus_write(A_BAUD, 32'd2, wc);
    exp_q.push_back('{8'h07, 2});
    bus_write(A_DATA, 32'h07, wc);
    wait_idle("byte07_drain", 100);

    // Register map corners
    bus_write(A_BAUD, 32'hFFFF_1234, wc);
    bus_read(A_BAUD, st);  check("baud_upper_zero", st, 32'h1234);
    @(negedge clk); sel = 1'b0; addr = A_BAUD; wdata = 32'h7; wstb = 4'b0001;
    @(posedge clk); #1; wstb = 4'b0000;
    bus_read(A_BAUD, st);  check("unselected_write_ignored", st, 32'h1234);
    bus_write(A_RSVD, 32'hFFFF_FFFF, wc);
    bus_read(A_RSVD, st);  check("reserved_read", st, 32'd0);
    bus_read(A_DATA, st);  check("data_read", st, 32'd0);
    bus_write(A_BAUD, 32'd0, wc);
    exp_q.push_back('{8'h5A, 1});
    bus_write(A_DATA, 32'h5A, wc);
    wait_idle("div0_drain", 100);

    // Overflow with div 1000, then async reset mid-frame
    bus_write(A_BAUD, 32'd1000, wc);
    exp_q.push_back('{8'h10, 1000});
    for (int i = 0; i < 10; i++) bus_write(A_DATA, 32'h10 + i, wc);
    bus_read(A_STAT, st);  check("ovf_status", st, 32'h80B | PAR_BIT);
    bus_write(A_STAT, 32'h8, wc);
    bus_read(A_STAT, st);  check("ovf_cleared", st, 32'h803 | PAR_BIT);
    check("ovf_tx_in_start", {31'd0, tx}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    bus_read(A_STAT, st);  check("post_reset_status", st, 32'h4 | PAR_BIT);
    bus_read(A_BAUD, st);  check("post_reset_baud", st, 32'd434);
    repeat (5) @(posedge clk);
    check("post_reset_tx_idle", {31'd0, tx}, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
